// File: rtl/wash_pkg.sv
// ----------------------------------------------------------------------------
// wash_pkg
// Shared definitions for the washing-machine timer / level-sense block:
//   - phase encoding (phase_t plus one constant per phase)
//   - default values for every wash_timer_sense parameter
//   - small helpers used by the counters and the phase decoder
// No ports (package).
// ----------------------------------------------------------------------------
package wash_pkg;

    typedef logic [2:0] phase_t;

    localparam logic [2:0] PH_IDLE     = 3'd0;
    localparam logic [2:0] PH_FILLING  = 3'd1;
    localparam logic [2:0] PH_WASHING  = 3'd2;
    localparam logic [2:0] PH_DRAINING = 3'd3;
    localparam logic [2:0] PH_SPINNING = 3'd4;
    localparam logic [2:0] PH_FAULT    = 3'd5;

    localparam logic [15:0] CYCLE_TICKS_DEF = 16'd1000;
    localparam logic [15:0] SPIN_TICKS_DEF  = 16'd500;
    localparam logic [7:0]  FILL_LEVEL_DEF  = 8'd200;
    localparam logic [7:0]  EMPTY_LEVEL_DEF = 8'd10;
    localparam logic [3:0]  DEBOUNCE_DEF    = 4'd8;
    localparam logic [15:0] VALVE_LIMIT_DEF = 16'd4000;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    // True when two or more of the three controller commands are active.
    function automatic logic multi_cmd(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/level_debounce.sv
// ----------------------------------------------------------------------------
// level_debounce
// Turns a per-cycle threshold comparison into a stable level. The output only
// flips after DEBOUNCE consecutive samples disagree with it; any sample that
// agrees with the current output restarts the count.
// Ports:
//   clk     in  1  system clock, rising edge
//   reset   in  1  asynchronous, active-low
//   sample  in  1  raw threshold comparison for this cycle
//   level   out 1  debounced (registered) level
// ----------------------------------------------------------------------------
module level_debounce
    import wash_pkg::*;
#(
    parameter logic [3:0] DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    output logic level
);

    logic [3:0] agree_cnt_r;
    logic       level_r;
    logic [4:0] agree_inc_s;
    logic [3:0] agree_cnt_next_s;
    logic       level_next_s;

    // Count disagreeing samples; flip the level once enough arrive in a row.
    always_comb begin
        agree_inc_s      = {1'b0, agree_cnt_r} + 5'd1;
        agree_cnt_next_s = 4'd0;
        level_next_s     = level_r;
        if (sample != level_r) begin
            if (agree_inc_s >= {1'b0, DEBOUNCE}) begin
                level_next_s     = sample;
                agree_cnt_next_s = 4'd0;
            end else begin
                agree_cnt_next_s = agree_inc_s[3:0];
            end
        end else begin
            agree_cnt_next_s = 4'd0;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            agree_cnt_r <= 4'd0;
            level_r     <= 1'b0;
        end else begin
            agree_cnt_r <= agree_cnt_next_s;
            level_r     <= level_next_s;
        end
    end

    assign level = level_r;

endmodule

// File: rtl/wash_timer_sense.sv
// ----------------------------------------------------------------------------
// wash_timer_sense
// Supervises a washing-machine controller: tracks the current phase from the
// motor / valve commands, times the wash and spin phases, limits how long a
// valve may stay open and debounces the water-level sensor.
// Ports:
//   clk            in  1  system clock, rising edge
//   reset          in  1  asynchronous, active-low
//   motor_on       in  1  wash motor command
//   fill_value_on  in  1  fill valve command
//   drain_value_on in  1  drain valve command
//   level_raw      in  8  water-level sample, valid every cycle
//   filled         out 1  debounced level_raw >= FILL_LEVEL
//   drained        out 1  debounced level_raw <= EMPTY_LEVEL
//   cycle_timeout  out 1  wash time elapsed, held while washing
//   spin_timeout   out 1  spin time elapsed, held while spinning
//   fault          out 1  sticky error, cleared only by reset
// ----------------------------------------------------------------------------
module wash_timer_sense
    import wash_pkg::*;
#(
    parameter logic [15:0] CYCLE_TICKS = CYCLE_TICKS_DEF,
    parameter logic [15:0] SPIN_TICKS  = SPIN_TICKS_DEF,
    parameter logic [7:0]  FILL_LEVEL  = FILL_LEVEL_DEF,
    parameter logic [7:0]  EMPTY_LEVEL = EMPTY_LEVEL_DEF,
    parameter logic [3:0]  DEBOUNCE    = DEBOUNCE_DEF,
    parameter logic [15:0] VALVE_LIMIT = VALVE_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       motor_on,
    input  logic       fill_value_on,
    input  logic       drain_value_on,
    input  logic [7:0] level_raw,
    output logic       filled,
    output logic       drained,
    output logic       cycle_timeout,
    output logic       spin_timeout,
    output logic       fault
);

    phase_t      phase_r;
    phase_t      decode_s;
    phase_t      phase_next_s;

    logic [15:0] wash_cnt_r;
    logic [15:0] spin_cnt_r;
    logic [15:0] valve_cnt_r;
    logic [15:0] wash_inc_s;
    logic [15:0] spin_inc_s;
    logic [15:0] valve_inc_s;
    logic [15:0] wash_cnt_next_s;
    logic [15:0] spin_cnt_next_s;
    logic [15:0] valve_cnt_next_s;

    logic        full_s;
    logic        empty_s;
    logic        valve_phase_s;
    logic        valve_stay_s;
    logic        valve_over_s;
    logic        wash_hold_s;
    logic        spin_hold_s;
    logic        valve_hold_s;

    logic        cycle_timeout_r;
    logic        spin_timeout_r;
    logic        fault_r;
    logic        cycle_timeout_next_s;
    logic        spin_timeout_next_s;
    logic        fault_next_s;

    // Raw threshold comparisons feeding the two debouncers.
    always_comb begin
        full_s  = (level_raw >= FILL_LEVEL);
        empty_s = (level_raw <= EMPTY_LEVEL);
    end

    level_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_full_debounce (
        .clk    (clk),
        .reset  (reset),
        .sample (full_s),
        .level  (filled)
    );

    level_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_empty_debounce (
        .clk    (clk),
        .reset  (reset),
        .sample (empty_s),
        .level  (drained)
    );

    // Phase requested by the controller this cycle. Conflicting commands are
    // treated as a fault before any single command is considered.
    always_comb begin
        decode_s = PH_IDLE;
        if (multi_cmd(motor_on, fill_value_on, drain_value_on)) begin
            decode_s = PH_FAULT;
        end else if (fill_value_on) begin
            decode_s = PH_FILLING;
        end else if (motor_on) begin
            decode_s = PH_WASHING;
        end else if (drain_value_on) begin
            // Once the drum is empty the drain command means the spin phase.
            if (drained) begin
                decode_s = PH_SPINNING;
            end else begin
                decode_s = PH_DRAINING;
            end
        end else begin
            decode_s = PH_IDLE;
        end
    end

    // Next phase, including the valve-open limit and the absorbing fault.
    always_comb begin
        valve_inc_s   = sat_inc16(valve_cnt_r);
        valve_phase_s = (phase_r == PH_FILLING) || (phase_r == PH_DRAINING);
        valve_stay_s  = valve_phase_s && (decode_s == phase_r);
        valve_over_s  = valve_stay_s && (valve_inc_s >= VALVE_LIMIT);
        phase_next_s  = PH_FAULT;
        case (phase_r)
            PH_IDLE, PH_FILLING, PH_WASHING, PH_DRAINING, PH_SPINNING: begin
                if (valve_over_s) begin
                    phase_next_s = PH_FAULT;
                end else begin
                    phase_next_s = decode_s;
                end
            end
            PH_FAULT: begin
                phase_next_s = PH_FAULT;
            end
            default: begin
                // Unreachable encodings are treated as a fault.
                phase_next_s = PH_FAULT;
            end
        endcase
    end

    // Counters advance only while the phase is unchanged across the edge, so
    // any phase change (including WASHING -> SPINNING) restarts them at zero.
    always_comb begin
        wash_inc_s   = sat_inc16(wash_cnt_r);
        spin_inc_s   = sat_inc16(spin_cnt_r);
        wash_hold_s  = (phase_r == PH_WASHING) && (phase_next_s == PH_WASHING);
        spin_hold_s  = (phase_r == PH_SPINNING) && (phase_next_s == PH_SPINNING);
        valve_hold_s = valve_phase_s && (phase_next_s == phase_r);

        if (wash_hold_s) begin
            wash_cnt_next_s = wash_inc_s;
        end else begin
            wash_cnt_next_s = 16'd0;
        end

        if (spin_hold_s) begin
            spin_cnt_next_s = spin_inc_s;
        end else begin
            spin_cnt_next_s = 16'd0;
        end

        if (valve_hold_s) begin
            valve_cnt_next_s = valve_inc_s;
        end else begin
            valve_cnt_next_s = 16'd0;
        end

        // Timeouts look at the post-edge count so they rise on the edge that
        // completes the last timed cycle, and drop on the edge that leaves.
        cycle_timeout_next_s = wash_hold_s && (wash_inc_s >= CYCLE_TICKS);
        spin_timeout_next_s  = spin_hold_s && (spin_inc_s >= SPIN_TICKS);
        fault_next_s         = (phase_next_s == PH_FAULT);
    end

    // Phase and timing counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_r     <= PH_IDLE;
            wash_cnt_r  <= 16'd0;
            spin_cnt_r  <= 16'd0;
            valve_cnt_r <= 16'd0;
        end else begin
            phase_r     <= phase_next_s;
            wash_cnt_r  <= wash_cnt_next_s;
            spin_cnt_r  <= spin_cnt_next_s;
            valve_cnt_r <= valve_cnt_next_s;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_timeout_r <= 1'b0;
            spin_timeout_r  <= 1'b0;
            fault_r         <= 1'b0;
        end else begin
            cycle_timeout_r <= cycle_timeout_next_s;
            spin_timeout_r  <= spin_timeout_next_s;
            fault_r         <= fault_next_s;
        end
    end

    assign cycle_timeout = cycle_timeout_r;
    assign spin_timeout  = spin_timeout_r;
    assign fault         = fault_r;

endmodule

// File: tb/tb_wash_timer_sense.sv
// ----------------------------------------------------------------------------
// tb_wash_timer_sense
// Table-driven bench for wash_timer_sense with CYCLE_TICKS=10, SPIN_TICKS=5,
// DEBOUNCE=3, VALVE_LIMIT=20. Each table row holds inputs, a repeat count and
// the outputs expected after every one of those clock edges, packed as
// {fault, spin_timeout, cycle_timeout, drained, filled}.
// ----------------------------------------------------------------------------
module tb_wash_timer_sense;

    logic       clk;
    logic       reset;
    logic       motor_on;
    logic       fill_value_on;
    logic       drain_value_on;
    logic [7:0] level_raw;
    logic       filled;
    logic       drained;
    logic       cycle_timeout;
    logic       spin_timeout;
    logic       fault;

    wash_timer_sense #(
        .CYCLE_TICKS (16'd10),
        .SPIN_TICKS  (16'd5),
        .FILL_LEVEL  (8'd200),
        .EMPTY_LEVEL (8'd10),
        .DEBOUNCE    (4'd3),
        .VALVE_LIMIT (16'd20)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .motor_on       (motor_on),
        .fill_value_on  (fill_value_on),
        .drain_value_on (drain_value_on),
        .level_raw      (level_raw),
        .filled         (filled),
        .drained        (drained),
        .cycle_timeout  (cycle_timeout),
        .spin_timeout   (spin_timeout),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       motor;
        bit       fill;
        bit       drain;
        bit [7:0] level;
        int       reps;
        bit [4:0] exp;
        string    name;
    } vec_t;

    typedef struct {
        bit [4:0] exp;
        string    name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_checks;
    int   n_fail;

    function automatic logic [4:0] outs();
        return {fault, spin_timeout, cycle_timeout, drained, filled};
    endfunction

    function automatic void add(bit rst, bit m, bit f, bit d, bit [7:0] lv,
                                int reps, bit [4:0] e, string nm);
        vec_t v;
        v.rst   = rst;
        v.motor = m;
        v.fill  = f;
        v.drain = d;
        v.level = lv;
        v.reps  = reps;
        v.exp   = e;
        v.name  = nm;
        vecs.push_back(v);
    endfunction

    task automatic check(input bit [4:0] exp, input string nm);
        logic [4:0] got;
        got = outs();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (fault,spin,cycle,drained,filled) t=%0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic drive(input bit m, input bit f, input bit d, input bit [7:0] lv);
        motor_on       = m;
        fill_value_on  = f;
        drain_value_on = d;
        level_raw      = lv;
    endtask

    // Pop the oldest expectation and compare it to the DUT outputs.
    task automatic compare_pop();
        sb_t item;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no entry expected one");
        end else begin
            item = sb_q.pop_front();
            check(item.exp, item.name);
        end
    endtask

    // Called at a negedge; asserts reset with the given inputs applied and
    // returns at a negedge with reset released.
    task automatic do_reset(input bit m, input bit f, input bit d, input bit [7:0] lv);
        drive(m, f, d, lv);
        reset = 1'b0;
        #1;
        check(5'b00000, "reset_immediate");
        repeat (2) @(posedge clk);
        #1;
        check(5'b00000, "reset_hold");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'd0);

        // Fill, level debounce and glitch rejection.
        add(1, 0, 1, 0, 8'd0,   2,  5'b00000, "fill_start");
        add(0, 0, 1, 0, 8'd0,   1,  5'b00010, "drained_set");
        add(0, 0, 1, 0, 8'd210, 1,  5'b00010, "glitch_hi1");
        add(0, 0, 1, 0, 8'd0,   1,  5'b00010, "glitch_lo");
        add(0, 0, 1, 0, 8'd210, 1,  5'b00010, "glitch_hi2");
        add(0, 0, 1, 0, 8'd210, 1,  5'b00010, "fill_deb2");
        add(0, 0, 1, 0, 8'd210, 1,  5'b00001, "filled_set");
        add(0, 0, 1, 0, 8'd100, 2,  5'b00001, "filled_hold");
        add(0, 0, 1, 0, 8'd100, 1,  5'b00000, "filled_clear");
        add(0, 0, 0, 0, 8'd100, 1,  5'b00000, "idle");
        // Wash timing: 12 motor cycles, timeout after the 10th.
        add(0, 1, 0, 0, 8'd100, 10, 5'b00000, "wash_count");
        add(0, 1, 0, 0, 8'd100, 1,  5'b00100, "wash_timeout");
        add(0, 1, 0, 0, 8'd100, 1,  5'b00100, "wash_hold");
        add(0, 0, 0, 0, 8'd100, 1,  5'b00000, "wash_release");
        // Drain to empty, then spin.
        add(0, 0, 0, 1, 8'd200, 2,  5'b00000, "drain_hi");
        add(0, 0, 0, 1, 8'd200, 1,  5'b00001, "drain_filled");
        add(0, 0, 0, 1, 8'd5,   2,  5'b00001, "drain_lo");
        add(0, 0, 0, 1, 8'd5,   1,  5'b00010, "drain_drained");
        add(0, 0, 0, 1, 8'd5,   5,  5'b00010, "spin_count");
        add(0, 0, 0, 1, 8'd5,   1,  5'b01010, "spin_timeout");
        add(0, 0, 0, 1, 8'd5,   1,  5'b01010, "spin_hold");
        add(0, 0, 0, 0, 8'd5,   1,  5'b00010, "spin_release");
        // WASHING straight into SPINNING: spin count starts from zero.
        add(0, 1, 0, 0, 8'd5,   9,  5'b00010, "wash_pre_spin");
        add(0, 0, 0, 1, 8'd5,   5,  5'b00010, "spin_direct");
        add(0, 0, 0, 1, 8'd5,   1,  5'b01010, "spin_direct_to");
        add(0, 0, 0, 0, 8'd5,   1,  5'b00010, "spin_direct_rel");
        // Valve left open too long.
        add(0, 0, 1, 0, 8'd50,  2,  5'b00010, "valve_deb");
        add(0, 0, 1, 0, 8'd50,  18, 5'b00000, "valve_count");
        add(0, 0, 1, 0, 8'd50,  1,  5'b10000, "valve_fault");
        add(0, 0, 0, 0, 8'd50,  2,  5'b10000, "fault_sticky");
        add(0, 1, 0, 0, 8'd50,  12, 5'b10000, "fault_no_timeout");
        add(0, 1, 0, 0, 8'd210, 2,  5'b10000, "fault_track");
        add(0, 1, 0, 0, 8'd210, 1,  5'b10001, "fault_filled");
        // Conflicting commands.
        add(1, 1, 1, 0, 8'd100, 1,  5'b10000, "multi_on_fault");
        add(0, 0, 0, 0, 8'd100, 1,  5'b10000, "multi_on_hold");
        // Reset in the middle of washing at count 7.
        add(1, 1, 0, 0, 8'd210, 2,  5'b00000, "wash_a");
        add(0, 1, 0, 0, 8'd210, 1,  5'b00001, "wash_a_filled");
        add(0, 1, 0, 0, 8'd210, 5,  5'b00001, "wash_a_cnt7");
        add(1, 1, 0, 0, 8'd210, 2,  5'b00000, "restart");
        add(0, 1, 0, 0, 8'd210, 1,  5'b00001, "restart_filled");
        add(0, 1, 0, 0, 8'd210, 7,  5'b00001, "restart_cnt");
        add(0, 1, 0, 0, 8'd210, 1,  5'b00101, "restart_timeout");

        @(negedge clk);
        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset(vecs[i].motor, vecs[i].fill, vecs[i].drain, vecs[i].level);
            end
            for (int r = 0; r < vecs[i].reps; r++) begin
                sb_t item;
                drive(vecs[i].motor, vecs[i].fill, vecs[i].drain, vecs[i].level);
                item.exp  = vecs[i].exp;
                item.name = vecs[i].name;
                sb_q.push_back(item);
                @(posedge clk);
                #1;
                compare_pop();
                @(negedge clk);
            end
        end

        // Reset dropped during the high clock phase clears outputs at once.
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check(5'b00000, "reset_async_hi");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd100);
        @(posedge clk);
        #1;
        check(5'b00000, "post_reset_idle");
        @(negedge clk);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
